maxpool2x2_stream: RTL

- Downstream stage of the convolution engine; consumes its output AXI-Stream, one signed result per beat, row-major.
- Performs 2x2 stride-2 signed max pooling over each Rin x Cin frame.
- Emits floor(Rin/2) x floor(Cin/2) results, row-major, with TLAST on the last result of the frame.
- Uses a half-row line buffer holding column-pair maxima from even rows.

---
 rtl/maxpool2x2_stream_if.sv | 23 ++
 rtl/maxpool2x2_stream.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream_if.sv
// Stream bundle for maxpool2x2_stream: conv-result input stream and pooled output stream.
// slave = pooling block side, master = producer/consumer side driving it.
interface maxpool2x2_stream_if #(
  parameter int W = 52
);
  logic [W-1:0] INPUT_TDATA;
  logic         INPUT_TVALID;
  logic         INPUT_TREADY;
  logic [W-1:0] OUTPUT_TDATA;
  logic         OUTPUT_TVALID;
  logic         OUTPUT_TLAST;
  logic         OUTPUT_TREADY;

  modport slave (
    input  INPUT_TDATA, INPUT_TVALID, OUTPUT_TREADY,
    output INPUT_TREADY, OUTPUT_TDATA, OUTPUT_TVALID, OUTPUT_TLAST
  );

  modport master (
    output INPUT_TDATA, INPUT_TVALID, OUTPUT_TREADY,
    input  INPUT_TREADY, OUTPUT_TDATA, OUTPUT_TVALID, OUTPUT_TLAST
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 signed max pooling over a row-major stream, half-row line buffer of pair maxima.
// Optional MAXPOOL_RELU_EN clamps every emitted result to max(result, 0).
module maxpool2x2_stream #(
  parameter  int W    = 52,
  parameter  int MAXR = 9,
  parameter  int MAXC = 8,
  localparam int RW   = $clog2(MAXR+1),
  localparam int CW   = $clog2(MAXC+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] CFG_ROWS,
  input  logic [CW-1:0] CFG_COLS,
  maxpool2x2_stream_if.slave s
);
  localparam int LBD = MAXC/2;
  localparam int LBW = (LBD > 1) ? $clog2(LBD) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        r_q, r_d, rows_q, rows_d;
  logic [CW-1:0]        c_q, c_d, cols_q, cols_d;
  logic signed [W-1:0]  pmax_q, pmax_d;
  logic signed [W-1:0]  odata_q, odata_d;
  logic                 ovld_q, ovld_d, olast_q, olast_d;
  logic signed [W-1:0]  lb_q [LBD];

  logic                 in_rdy, acc, first, lb_we, row_end, frame_end;
  logic [RW-1:0]        rows_e, r_e, rows_ev;
  logic [CW-1:0]        cols_e, c_e, cols_ev;
  logic [LBW-1:0]       idx;
  logic signed [W-1:0]  x, pm2, win, win_o;

  function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign in_rdy         = (state_q != DRAIN) && (!ovld_q || s.OUTPUT_TREADY);
  assign acc            = s.INPUT_TVALID && in_rdy;
  assign s.INPUT_TREADY = in_rdy;
  assign s.OUTPUT_TDATA = odata_q;
  assign s.OUTPUT_TVALID = ovld_q;
  assign s.OUTPUT_TLAST = olast_q;

  // In IDLE the arriving beat is position (0,0) of a frame sized by the live config.
  assign first   = (state_q == IDLE);
  assign rows_e  = first ? CFG_ROWS : rows_q;
  assign cols_e  = first ? CFG_COLS : cols_q;
  assign r_e     = first ? '0 : r_q;
  assign c_e     = first ? '0 : c_q;
  assign rows_ev = {rows_e[RW-1:1], 1'b0};
  assign cols_ev = {cols_e[CW-1:1], 1'b0};
  assign idx     = c_e[LBW:1];
  assign x       = s.INPUT_TDATA;
  assign pm2     = smax(pmax_q, x);
  assign win     = smax(lb_q[idx], pm2);

`ifdef MAXPOOL_RELU_EN
  assign win_o = win[W-1] ? '0 : win;
`else
  assign win_o = win;
`endif

  assign row_end   = (c_e == cols_e - CW'(1));
  assign frame_end = row_end && (r_e == rows_e - RW'(1));

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    pmax_d  = pmax_q;
    odata_d = odata_q;
    ovld_d  = ovld_q;
    olast_d = olast_q;
    lb_we   = 1'b0;

    if (ovld_q && s.OUTPUT_TREADY) begin
      ovld_d  = 1'b0;
      olast_d = 1'b0;
    end

    if (acc) begin
      rows_d = rows_e;
      cols_d = cols_e;
      if (!c_e[0]) pmax_d = x;
      // Trailing odd column/row beats fall through here and are dropped.
      if (c_e[0] && (c_e < cols_ev)) begin
        if (!r_e[0] && (r_e < rows_ev)) begin
          lb_we = 1'b1;
        end else if (r_e[0]) begin
          odata_d = win_o;
          ovld_d  = 1'b1;
          olast_d = (r_e == rows_ev - RW'(1)) && (c_e == cols_ev - CW'(1));
        end
      end
      if (row_end) begin
        c_d = '0;
        r_d = frame_end ? '0 : r_e + RW'(1);
      end else begin
        c_d = c_e + CW'(1);
        r_d = r_e;
      end
      if (frame_end) state_d = ovld_d ? DRAIN : IDLE;
      else           state_d = RUN;
    end else if (state_q == DRAIN && s.OUTPUT_TREADY) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      pmax_q  <= '0;
      odata_q <= '0;
      ovld_q  <= 1'b0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      pmax_q  <= pmax_d;
      odata_q <= odata_d;
      ovld_q  <= ovld_d;
      olast_q <= olast_d;
    end
  end

  // Line buffer holds even-row pair maxima; contents are not reset.
  always_ff @(posedge clk) begin
    if (lb_we) lb_q[idx] <= pm2;
  end
endmodule
